// File: rtl/rf_pkg.sv
// Shared definitions for the register-file sequencer: widths, opcodes and FSM states.
package rf_pkg;

    localparam int unsigned RF_DW = 3;
    localparam int unsigned RF_AW = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_MOVE = 2'b10,
        OP_OUT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_EX   = 2'b10,
        S_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational add/pass unit for the sequencer's EX stage.
// With SAT_ADD_EN defined, an ADD that carries out clamps to all-ones instead of wrapping.
module rf_seq_alu
    import rf_pkg::*;
#(
    parameter int unsigned DW = RF_DW
) (
    input  logic          i_add,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_res_c,
    output logic          o_carry_c
);

    logic [DW:0] w_sum;

    always_comb begin
        w_sum     = (DW+1)'(i_a) + (DW+1)'(i_b);
        o_carry_c = i_add & w_sum[DW];
        o_res_c   = i_a;
        if (i_add) begin
`ifdef SAT_ADD_EN
            o_res_c = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
`else
            o_res_c = w_sum[DW-1:0];
`endif
        end
    end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle controller driving a two-read/one-write register file (IDLE->RD->EX->WB).
// Optional SAT_ADD_EN macro selects saturating ADD inside rf_seq_alu.
module rf_sequencer
    import rf_pkg::*;
#(
    parameter int unsigned DW = RF_DW,
    parameter int unsigned AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [1:0]    instr_op,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_sa,
    input  logic [AW-1:0] instr_sb,
    input  logic [DW-1:0] instr_imm,
    output logic          rf_rea,
    output logic          rf_reb,
    output logic [AW-1:0] rf_raa,
    output logic [AW-1:0] rf_rab,
    input  logic [DW-1:0] rf_douta,
    input  logic [DW-1:0] rf_doutb,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_din,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          done,
    output logic          ovf
);

    state_e        r_state, w_state_nxt;
    op_e           r_op;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_opa, r_opb;

    logic          r_ready, r_rea, r_reb, r_we, r_rv, r_done, r_ovf;
    logic [AW-1:0] r_raa, r_rab, r_wa;
    logic [DW-1:0] r_din, r_result;

    logic          w_ready, w_rea, w_reb, w_we, w_rv, w_done, w_ovf;
    logic [AW-1:0] w_raa, w_rab, w_wa;
    logic [DW-1:0] w_din, w_result;

    logic          w_accept;
    op_e           w_op_in;
    logic [DW-1:0] w_alu_res;
    logic          w_alu_carry;

    assign w_op_in  = op_e'(instr_op);
    assign w_accept = instr_valid & r_ready;

    rf_seq_alu #(.DW(DW)) u_alu (
        .i_add     (r_op == OP_ADD),
        .i_a       (r_opa),
        .i_b       (r_opb),
        .o_res_c   (w_alu_res),
        .o_carry_c (w_alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Outputs are computed for the state being entered so every port comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_rea       = 1'b0;
        w_reb       = 1'b0;
        w_raa       = '0;
        w_rab       = '0;
        w_we        = 1'b0;
        w_wa        = '0;
        w_din       = '0;
        w_done      = 1'b0;
        w_rv        = 1'b0;
        w_result    = r_result;
        w_ovf       = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op_in == OP_LOAD) begin
                        w_state_nxt = S_WB;
                        w_we        = 1'b1;
                        w_wa        = instr_dst;
                        w_din       = instr_imm;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = S_RD;
                        w_rea       = 1'b1;
                        w_raa       = instr_sa;
                        if (w_op_in == OP_ADD) begin
                            w_reb = 1'b1;
                            w_rab = instr_sb;
                        end
                    end
                end
            end
            S_RD: w_state_nxt = S_EX;
            S_EX: begin
                w_state_nxt = S_WB;
                w_done      = 1'b1;
                if (r_op == OP_OUT) begin
                    w_result = w_alu_res;
                    w_rv     = 1'b1;
                end else begin
                    w_we  = 1'b1;
                    w_wa  = r_dst;
                    w_din = w_alu_res;
                end
                w_ovf = r_ovf | w_alu_carry;
            end
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_ready = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_LOAD;
            r_dst    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_ready  <= 1'b1;
            r_rea    <= 1'b0;
            r_reb    <= 1'b0;
            r_raa    <= '0;
            r_rab    <= '0;
            r_we     <= 1'b0;
            r_wa     <= '0;
            r_din    <= '0;
            r_result <= '0;
            r_rv     <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_op  <= w_op_in;
                r_dst <= instr_dst;
            end
            if (r_state == S_RD) begin
                r_opa <= rf_douta;
                r_opb <= rf_doutb;
            end
            r_ready  <= w_ready;
            r_rea    <= w_rea;
            r_reb    <= w_reb;
            r_raa    <= w_raa;
            r_rab    <= w_rab;
            r_we     <= w_we;
            r_wa     <= w_wa;
            r_din    <= w_din;
            r_result <= w_result;
            r_rv     <= w_rv;
            r_done   <= w_done;
            r_ovf    <= w_ovf;
        end
    end

    assign instr_ready  = r_ready;
    assign rf_rea       = r_rea;
    assign rf_reb       = r_reb;
    assign rf_raa       = r_raa;
    assign rf_rab       = r_rab;
    assign rf_we        = r_we;
    assign rf_wa        = r_wa;
    assign rf_din       = r_din;
    assign result       = r_result;
    assign result_valid = r_rv;
    assign done         = r_done;
    assign ovf          = r_ovf;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer attached to a behavioural 4x3 register file; scoreboard of expected retirements.
module tb_rf_sequencer;
    import rf_pkg::*;

    localparam int unsigned DW = RF_DW;
    localparam int unsigned AW = RF_AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [1:0]    instr_op = 2'b00;
    logic [AW-1:0] instr_dst = '0, instr_sa = '0, instr_sb = '0;
    logic [DW-1:0] instr_imm = '0;
    logic          rf_rea, rf_reb, rf_we;
    logic [AW-1:0] rf_raa, rf_rab, rf_wa;
    logic [DW-1:0] rf_douta, rf_doutb, rf_din;
    logic [DW-1:0] result;
    logic          result_valid, done, ovf;

    always #5 clk = ~clk;

    rf_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst), .instr_sa(instr_sa),
        .instr_sb(instr_sb), .instr_imm(instr_imm),
        .rf_rea(rf_rea), .rf_reb(rf_reb), .rf_raa(rf_raa), .rf_rab(rf_rab),
        .rf_douta(rf_douta), .rf_doutb(rf_doutb),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_din(rf_din),
        .result(result), .result_valid(result_valid), .done(done), .ovf(ovf)
    );

    // Register file: combinational reads, clocked write, not reset.
    logic [DW-1:0] rf_mem [4] = '{default: '0};
    assign rf_douta = rf_rea ? rf_mem[rf_raa] : '0;
    assign rf_doutb = rf_reb ? rf_mem[rf_rab] : '0;
    always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_din;

    typedef struct {
        op_e           op;
        logic [AW-1:0] sa, sb;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] din;
        logic          rv;
        logic [DW-1:0] res;
        logic          ovf;
        int unsigned   cyc;
    } exp_t;

    exp_t          q[$];
    int            n_chk = 0, n_err = 0;
    int unsigned   cyc = 0;
    int            we_cnt = 0, done_cnt = 0, acc_cnt = 0;
    logic [DW-1:0] m_rf [4] = '{default: '0};
    logic          m_ovf = 1'b0;
    logic [DW-1:0] m_result = '0;
    logic          ovf_pend = 1'b0, ovf_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Retirement monitor: pops the scoreboard on done, checks read-port activity in RD.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ovf_pend) begin
                chk("ovf", 32'(ovf), 32'(ovf_exp));
                ovf_pend = 1'b0;
            end
            if (instr_valid && instr_ready) acc_cnt++;
            if (rf_we) we_cnt++;
            if (rf_rea || rf_reb) begin
                chk("ready_in_rd", 32'(instr_ready), 32'd0);
                if (q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    chk("rf_rea", 32'(rf_rea), 32'd1);
                    chk("rf_raa", 32'(rf_raa), 32'(q[0].sa));
                    chk("rf_reb", 32'(rf_reb), 32'(q[0].op == OP_ADD));
                    if (q[0].op == OP_ADD) chk("rf_rab", 32'(rf_rab), 32'(q[0].sb));
                end
            end
            if (done) begin
                done_cnt++;
                chk("ready_in_wb", 32'(instr_ready), 32'd0);
                if (q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.cyc));
                    chk("rf_we", 32'(rf_we), 32'(e.we));
                    if (e.we) begin
                        chk("rf_wa", 32'(rf_wa), 32'(e.wa));
                        chk("rf_din", 32'(rf_din), 32'(e.din));
                    end
                    chk("result_valid", 32'(result_valid), 32'(e.rv));
                    if (e.rv) chk("result", 32'(result), 32'(e.res));
                    ovf_exp  = e.ovf;
                    ovf_pend = 1'b1;
                end
            end else begin
                if (rf_we) chk("we_without_done", 32'd1, 32'd0);
                if (result_valid) chk("rv_without_done", 32'd1, 32'd0);
            end
        end
    end

    task automatic send(input op_e op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                        input logic [AW-1:0] sb, input logic [DW-1:0] imm, input bit hold);
        exp_t        e;
        int          n;
        logic [DW:0] sum;
        n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_dst   = dst;
        instr_sa    = sa;
        instr_sb    = sb;
        instr_imm   = imm;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        e.op = op; e.sa = sa; e.sb = sb;
        e.we = 1'b0; e.wa = '0; e.din = '0; e.rv = 1'b0;
        case (op)
            OP_LOAD: begin
                e.we = 1'b1; e.wa = dst; e.din = imm;
            end
            OP_ADD: begin
                sum   = {1'b0, m_rf[sa]} + {1'b0, m_rf[sb]};
                e.din = sum[DW-1:0];
`ifdef SAT_ADD_EN
                if (sum[DW]) e.din = '1;
`endif
                if (sum[DW]) m_ovf = 1'b1;
                e.we = 1'b1; e.wa = dst;
            end
            OP_MOVE: begin
                e.we = 1'b1; e.wa = dst; e.din = m_rf[sa];
            end
            default: begin
                e.rv = 1'b1; m_result = m_rf[sa];
            end
        endcase
        if (e.we) m_rf[dst] = e.din;
        e.res = m_result;
        e.ovf = m_ovf;
        e.cyc = cyc + ((op == OP_LOAD) ? 1 : 3);
        q.push_back(e);
        @(posedge clk);
        if (!hold) begin
            #1;
            instr_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_rd_ports"}, 32'({rf_rea, rf_reb, rf_raa, rf_rab}), 32'd0);
        chk({tag, "_wr_port"}, 32'({rf_we, rf_wa, rf_din}), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_flags"}, 32'({result_valid, done, ovf}), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] snap [4];
        int            we0, done0, acc0;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Abort an ADD in its RD cycle with an asynchronous reset.
        snap = m_rf;
        we0  = we_cnt;
        send(OP_ADD, 2'd3, 2'd0, 2'd1, 3'd0, 1'b0);
        chk("pre_abort_rea", 32'(rf_rea), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        q.delete();
        m_rf = snap; m_ovf = 1'b0; m_result = '0; ovf_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_we_after_abort", 32'(we_cnt), 32'(we0));

        send(OP_LOAD, 2'd2, 2'd0, 2'd0, 3'd5, 1'b0);
        send(OP_OUT,  2'd0, 2'd2, 2'd0, 3'd0, 1'b0);
        drain();

        send(OP_LOAD, 2'd1, 2'd0, 2'd0, 3'd4, 1'b0);
        send(OP_MOVE, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0);
        send(OP_OUT,  2'd0, 2'd1, 2'd0, 3'd0, 1'b0);
        drain();

        send(OP_LOAD, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0);
        send(OP_ADD,  2'd2, 2'd2, 2'd2, 3'd0, 1'b0);
        send(OP_OUT,  2'd0, 2'd2, 2'd0, 3'd0, 1'b0);
        drain();
        chk("ovf_clear_before_carry", 32'(ovf), 32'd0);

        send(OP_LOAD, 2'd0, 2'd0, 2'd0, 3'd3, 1'b0);
        send(OP_LOAD, 2'd1, 2'd0, 2'd0, 3'd6, 1'b0);
        send(OP_ADD,  2'd3, 2'd0, 2'd1, 3'd0, 1'b0);
        send(OP_OUT,  2'd0, 2'd3, 2'd0, 3'd0, 1'b0);
        drain();
        chk("ovf_after_carry", 32'(ovf), 32'd1);

        // Four instructions with instr_valid held high throughout.
        done0 = done_cnt;
        acc0  = acc_cnt;
        send(OP_LOAD, 2'd0, 2'd0, 2'd0, 3'd7, 1'b1);
        send(OP_MOVE, 2'd2, 2'd0, 2'd0, 3'd0, 1'b1);
        send(OP_ADD,  2'd1, 2'd2, 2'd0, 3'd0, 1'b1);
        send(OP_OUT,  2'd0, 2'd1, 2'd0, 3'd0, 1'b0);
        drain();
        repeat (4) @(negedge clk);
        chk("held_done_count", 32'(done_cnt - done0), 32'd4);
        chk("held_accept_count", 32'(acc_cnt - acc0), 32'd4);

        for (int i = 0; i < 4; i++) chk($sformatf("rf_mem_r%0d", i), 32'(rf_mem[i]), 32'(m_rf[i]));
        chk("result_hold", 32'(result), 32'(m_result));
        chk("ovf_sticky", 32'(ovf), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
